rx_dcoffset_mc: RTL and testbench

- Multi-channel, parametrised DC-offset remover for the RX ADC path.
- Sits between the ADC input registers and the DDC.
- Each channel runs an independent first-order integrator that estimates DC and subtracts it from the sample stream.
- Runtime controls: time constant, per-channel manual/hold offset, global freeze. Output is saturating and carries a valid strobe.

---
 rtl/rx_dcoffset_mc.sv | 106 ++++++++++
 tb/tb_rx_dcoffset_mc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_dcoffset_mc.sv
// rtl/rx_dcoffset_mc.sv - multi-channel DC-offset remover with per-channel hold and saturating output
// Optional readback port (rb_sel/rb_data) is built when DCOFFSET_READBACK_EN is defined.
module rx_dcoffset_mc #(
  parameter int WIDTH         = 14,
  parameter int NCH           = 2,
  parameter int ADDR          = 0,
  parameter int ALPHA_DEFAULT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_stb,
  input  logic [7:0]           set_addr,
  input  logic [31:0]          set_data,
  input  logic                 freeze,
  input  logic [NCH*WIDTH-1:0] in_tdata,
  input  logic                 in_tvalid,
`ifdef DCOFFSET_READBACK_EN
  input  logic [7:0]           rb_sel,
  output logic [31:0]          rb_data,
`endif
  output logic [NCH*WIDTH-1:0] out_tdata,
  output logic                 out_tvalid
);

  localparam int AW = WIDTH + 17;
  localparam int RW = WIDTH + 18;
  localparam int OW = WIDTH + 1;
  localparam int EW = WIDTH + 2;
  localparam logic signed [EW-1:0] SAT_MAX = EW'((1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = EW'(-(1 <<< (WIDTH - 1)));

  logic signed [AW-1:0]  acc  [NCH];
  logic signed [OW-1:0]  off  [NCH];
  logic signed [EW-1:0]  err  [NCH];
  logic signed [AW-1:0]  step [NCH];
  logic [NCH-1:0]        hold;
  logic [NCH-1:0]        ch_wr;
  logic [3:0]            alpha;
  logic [4:0]            shamt;
  logic signed [AW-1:0]  load_val;
  logic [NCH*WIDTH-1:0]  sat_data;
  logic                  alpha_wr;
  logic                  unused_set_bits;

  assign unused_set_bits = ^set_data[30:WIDTH];
  assign shamt           = 5'd16 - {1'b0, alpha};
  assign load_val        = {set_data[WIDTH-1], set_data[WIDTH-1:0], 16'b0};
  assign alpha_wr        = set_stb && (set_addr == 8'(ADDR + NCH));

  always_comb begin
    sat_data = '0;
    ch_wr    = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_wr[k] = set_stb && (set_addr == 8'(ADDR + k));
      // Round half up, then drop the 16 fractional bits.
      off[k]   = OW'((RW'(acc[k]) + RW'(32'sd32768)) >>> 16);
      err[k]   = EW'($signed(in_tdata[k*WIDTH +: WIDTH])) - EW'(off[k]);
      step[k]  = AW'(err[k]) <<< shamt;
      if (err[k] > SAT_MAX)
        sat_data[k*WIDTH +: WIDTH] = SAT_MAX[WIDTH-1:0];
      else if (err[k] < SAT_MIN)
        sat_data[k*WIDTH +: WIDTH] = SAT_MIN[WIDTH-1:0];
      else
        sat_data[k*WIDTH +: WIDTH] = err[k][WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) acc[k] <= '0;
      hold       <= '0;
      alpha      <= 4'(ALPHA_DEFAULT);
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
    end else begin
      out_tvalid <= in_tvalid;
      if (in_tvalid) out_tdata <= sat_data;
      if (alpha_wr) alpha <= set_data[3:0];
      for (int k = 0; k < NCH; k++) begin
        // A hold load on the same cycle as a valid sample overrides the integrator step.
        if (ch_wr[k] && set_data[31])
          acc[k] <= load_val;
        else if (in_tvalid && !freeze && !hold[k])
          acc[k] <= acc[k] + step[k];
        if (ch_wr[k]) hold[k] <= set_data[31];
      end
    end
  end

`ifdef DCOFFSET_READBACK_EN
  logic [31:0] rb_next;

  always_comb begin
    rb_next = '0;
    if (rb_sel == 8'(NCH)) rb_next = {28'b0, alpha};
    for (int k = 0; k < NCH; k++)
      if (rb_sel == 8'(k)) rb_next = {hold[k], 15'b0, 16'(off[k])};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rb_data <= '0;
    else        rb_data <= rb_next;
  end
`endif

endmodule

// File: tb/tb_rx_dcoffset_mc.sv
// tb/tb_rx_dcoffset_mc.sv - self-checking bench for rx_dcoffset_mc with reference model and scoreboard
module tb_rx_dcoffset_mc;
  localparam int W = 14;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           set_stb = 1'b0;
  logic [7:0]     set_addr = '0;
  logic [31:0]    set_data = '0;
  logic           freeze = 1'b0;
  logic [N*W-1:0] in_tdata = '0;
  logic           in_tvalid = 1'b0;
  logic [N*W-1:0] out_tdata;
  logic           out_tvalid;
`ifdef DCOFFSET_READBACK_EN
  logic [7:0]     rb_sel = '0;
  logic [31:0]    rb_data;
`endif

  always #5 clk = ~clk;

  rx_dcoffset_mc #(.WIDTH(W), .NCH(N), .ADDR(0), .ALPHA_DEFAULT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .freeze     (freeze),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
`ifdef DCOFFSET_READBACK_EN
    .rb_sel     (rb_sel),
    .rb_data    (rb_data),
`endif
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid)
  );

  typedef struct { logic [31:0] hold_word; int din; int dout; } sat_vec_t;
  typedef struct { int e0; int e1; } exp_t;

  exp_t     sb[$];
  sat_vec_t sat_tab[7];
  int       checks = 0;
  int       failures = 0;
  longint   macc[N];
  bit       mhold[N];
  int       malpha;
  int       got0, got1, last0, last1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int moff(input longint a);
    return int'((a + 64'sd32768) >>> 16);
  endfunction

  function automatic int msat(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic void mreset();
    for (int k = 0; k < N; k++) begin
      macc[k]  = 0;
      mhold[k] = 1'b0;
    end
    malpha = 8;
  endfunction

  task automatic step(input bit stb, input logic [7:0] addr, input logic [31:0] data,
                      input bit frz, input bit v, input int d0, input int d1,
                      input bit force0 = 1'b0, input int x0 = 0);
    int   dd[N];
    int   e[N];
    exp_t ex;
    set_stb   = stb;
    set_addr  = addr;
    set_data  = data;
    freeze    = frz;
    in_tvalid = v;
    in_tdata  = {14'(d1), 14'(d0)};
    dd[0] = d0;
    dd[1] = d1;
    for (int k = 0; k < N; k++) e[k] = msat(dd[k] - moff(macc[k]));
    if (force0) e[0] = x0;
    if (v) begin
      ex.e0 = e[0];
      ex.e1 = e[1];
      sb.push_back(ex);
    end
    for (int k = 0; k < N; k++) begin
      bit wr;
      wr = stb && (addr == 8'(k));
      if (wr && data[31])
        macc[k] = longint'($signed(data[13:0])) * 65536;
      else if (v && !frz && !mhold[k]) begin
        macc[k] = macc[k] + longint'(dd[k] - moff(macc[k])) * (longint'(1) <<< (16 - malpha));
        macc[k] = (macc[k] <<< 33) >>> 33;
      end
      if (wr) mhold[k] = data[31];
    end
    if (stb && addr == 8'(N)) malpha = int'(data[3:0]);
    @(posedge clk);
    #1;
    got0 = int'($signed(out_tdata[13:0]));
    got1 = int'($signed(out_tdata[27:14]));
    check("out_tvalid", int'(out_tvalid), int'(v));
    if (out_tvalid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=output_present required=no_output");
      end else begin
        ex = sb.pop_front();
        check("out_ch0", got0, ex.e0);
        check("out_ch1", got1, ex.e1);
        last0 = ex.e0;
        last1 = ex.e1;
      end
    end else begin
      check("held_ch0", got0, last0);
      check("held_ch1", got1, last1);
    end
    @(negedge clk);
  endtask

  task automatic sample(input int d0, input int d1);
    step(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, d0, d1);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    step(1'b1, addr, data, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    sat_tab[0] = '{32'h8000_2000,  8191,  8191};
    sat_tab[1] = '{32'h8000_1FFF, -8192, -8192};
    sat_tab[2] = '{32'h8000_0000,  1234,  1234};
    sat_tab[3] = '{32'h8000_3FFF, -8192, -8191};
    sat_tab[4] = '{32'h8000_0064, -8000, -8100};
    sat_tab[5] = '{32'h8000_2000,    -1,  8191};
    sat_tab[6] = '{32'h8000_1FFF,  8191,     0};
    mreset();
    last0 = 0;
    last1 = 0;

    repeat (3) @(negedge clk);
    check("reset_tvalid", int'(out_tvalid), 0);
    check("reset_tdata", int'(out_tdata), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Step convergence, alpha = 4
    wr(8'd2, 32'd4);
    sample(100, 0);
    check("first_out_ch0", got0, 100);
    for (int i = 1; i < 200; i++) sample(100, 0);
    check("conv_ch0_within1", int'(got0 >= -1 && got0 <= 1), 1);
    for (int i = 0; i < 50; i++) sample(100, 0);
`ifdef DCOFFSET_READBACK_EN
    rb_sel = 8'd0;
    sample(100, 0);
    check("rb_off0", int'($signed(rb_data[15:0])), 100);
    check("rb_hold0", int'(rb_data[31]), 0);
    rb_sel = 8'd2;
    sample(100, 0);
    check("rb_alpha", int'(rb_data), 4);
`endif

    // Manual hold at 50, then release and reconverge
    wr(8'd0, 32'h8000_0032);
    for (int i = 0; i < 1000; i++) sample(100, 0);
    check("hold_out_ch0", got0, 50);
    wr(8'd0, 32'h0000_0000);
    for (int i = 0; i < 300; i++) sample(100, 0);
    check("release_conv_ch0", int'(got0 >= -1 && got0 <= 1), 1);

    // Saturation table
    foreach (sat_tab[i]) begin
      wr(8'd0, sat_tab[i].hold_word);
      step(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, sat_tab[i].din, 0, 1'b1, sat_tab[i].dout);
    end
    wr(8'd0, 32'h0000_0000);

    // Channel independence and collision, alpha = 6
    wr(8'd2, 32'd6);
    for (int i = 0; i < 150; i++) sample(200, -300);
    step(1'b1, 8'd1, 32'h8000_0010, 1'b0, 1'b1, 200, -300);
    step(1'b1, 8'd1, 32'h0000_0000, 1'b0, 1'b1, 200, -300);
    for (int i = 0; i < 600; i++) sample(200, -300);
    check("indep_conv_ch0", int'(got0 >= -1 && got0 <= 1), 1);
    check("indep_conv_ch1", int'(got1 >= -1 && got1 <= 1), 1);

    // Valid gaps, then freeze
    for (int i = 0; i < 40; i++)
      step(1'b0, 8'd0, 32'd0, 1'b0, (i % 2) == 0, 500, 0);
    for (int i = 0; i < 50; i++)
      step(1'b0, 8'd0, 32'd0, 1'b1, 1'b1, 500, 40);
    for (int i = 0; i < 100; i++) sample(500, 40);

    // Reset mid-stream with ch1 held
    wr(8'd1, 32'h8000_0020);
    for (int i = 0; i < 20; i++) sample(100, 100);
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", int'(out_tvalid), 0);
    check("async_rst_tdata", int'(out_tdata), 0);
    sb.delete();
    mreset();
    last0 = 0;
    last1 = 0;
    set_stb   = 1'b0;
    in_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sample(100, 100);
    check("post_rst_ch0", got0, 100);
    for (int i = 0; i < 150; i++) sample(100, 100);

    step(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 0, 0);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
